// File: rtl/spi_3wire_peripheral.sv
// Target end of the 3-wire half-duplex SPI link: oversamples SCK/CS/DIO on clk,
// collects write bytes, then drives response bytes after a programmed turnaround.
module spi_3wire_peripheral #(
    parameter int RX_BYTES    = 8,
    parameter int TX_BYTES    = 4,
    parameter int RX_SZ       = $clog2(RX_BYTES + 1),
    parameter int TX_SZ       = $clog2(TX_BYTES + 1),
    parameter bit LSB_FIRST   = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  dio_i,
    output logic                  dio_o,
    output logic                  dio_e,
    input  logic [RX_SZ-1:0]      turnaround,
    input  logic [TX_SZ-1:0]      tx_count,
    input  logic [8*TX_BYTES-1:0] tx_data,
    output logic [7:0]            rx_byte,
    output logic                  rx_byte_valid,
    output logic [8*RX_BYTES-1:0] rx_data,
    output logic [RX_SZ-1:0]      rx_len,
    output logic                  frame_done,
    output logic                  rx_overflow,
    output logic                  rx_partial,
    output logic                  busy
);
    // state | meaning
    // IDLE  | waiting for a fresh CS fall
    // RX    | shifting in controller write bytes
    // TX    | driving response bytes on the shared line
    // HOLD  | response done, line released, waiting for CS rise
    typedef enum logic [1:0] {IDLE, RX, TX, HOLD} state_t;

    localparam logic [RX_SZ-1:0] RX_MAX = RX_SZ'(RX_BYTES);

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, dio_sync_q;
    logic                   sck_prev_q, cs_prev_q;
    logic                   sck_s, cs_s, dio_s;
    logic                   sck_rise, sck_fall, cs_fall, cs_rise;

    // cs resets to "asserted" so a CS already low at reset release never looks like a fresh fall
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync_q <= '1;
            cs_sync_q  <= '0;
            dio_sync_q <= '0;
            sck_prev_q <= 1'b1;
            cs_prev_q  <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            dio_sync_q <= {dio_sync_q[SYNC_STAGES-2:0], dio_i};
            sck_prev_q <= sck_s;
            cs_prev_q  <= cs_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign dio_s    = dio_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;

    state_t                state_q, state_d;
    logic [RX_SZ-1:0]      ta_q, ta_d, rx_cnt_q, rx_cnt_d, rx_len_q, rx_len_d;
    logic [TX_SZ-1:0]      txc_q, txc_d, tx_idx_q, tx_idx_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d, rx_byte_q, rx_byte_d;
    logic [8*RX_BYTES-1:0] rx_data_q, rx_data_d;
    logic [8*TX_BYTES-1:0] tx_buf_q, tx_buf_d;
    logic                  tx_loaded_q, tx_loaded_d;
    logic                  rx_valid_q, rx_valid_d, frame_done_q, frame_done_d;
    logic                  ovf_q, ovf_d, partial_q, partial_d, busy_q, busy_d;
    logic                  dio_o_q, dio_o_d, dio_e_q, dio_e_d;

    logic [7:0]       shifted, cur_buf, cur_in;
    logic [RX_SZ-1:0] rx_cnt_nxt;
    logic [2:0]       bit_pos;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        ta_d         = ta_q;
        txc_d        = txc_q;
        rx_cnt_d     = rx_cnt_q;
        rx_len_d     = rx_len_q;
        tx_idx_d     = tx_idx_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_byte_d    = rx_byte_q;
        rx_data_d    = rx_data_q;
        tx_buf_d     = tx_buf_q;
        tx_loaded_d  = tx_loaded_q;
        ovf_d        = ovf_q;
        partial_d    = partial_q;
        busy_d       = busy_q;
        dio_o_d      = dio_o_q;
        dio_e_d      = dio_e_q;
        rx_valid_d   = 1'b0;
        frame_done_d = 1'b0;

        shifted    = LSB_FIRST ? {dio_s, shift_q[7:1]} : {shift_q[6:0], dio_s};
        rx_cnt_nxt = (rx_cnt_q == '1) ? rx_cnt_q : rx_cnt_q + 1'b1;
        bit_pos    = LSB_FIRST ? bit_cnt_q : 3'd7 - bit_cnt_q;
        cur_buf    = 8'h00;
        cur_in     = 8'h00;
        for (int i = 0; i < TX_BYTES; i++) begin
            if (TX_SZ'(i) == tx_idx_q) begin
                cur_buf = tx_buf_q[8*i +: 8];
                cur_in  = tx_data[8*i +: 8];
            end
        end

        // CS rise outranks any SCK edge detected in the same cycle
        if (state_q != IDLE && cs_rise) begin
            dio_e_d      = 1'b0;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
            if (state_q == RX && bit_cnt_q != 3'd0) partial_d = 1'b1;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        ta_d      = turnaround;
                        txc_d     = tx_count;
                        rx_len_d  = '0;
                        rx_cnt_d  = '0;
                        ovf_d     = 1'b0;
                        partial_d = 1'b0;
                        bit_cnt_d = 3'd0;
                        busy_d    = 1'b1;
                        state_d   = RX;
                    end
                end
                RX: begin
                    if (sck_rise) begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_byte_d  = shifted;
                            rx_valid_d = 1'b1;
                            rx_cnt_d   = rx_cnt_nxt;
                            if (rx_len_q < RX_MAX) begin
                                for (int i = 0; i < RX_BYTES; i++)
                                    if (RX_SZ'(i) == rx_len_q) rx_data_d[8*i +: 8] = shifted;
                                rx_len_d = rx_len_q + 1'b1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                            if (ta_q != '0 && rx_cnt_nxt == ta_q) begin
                                tx_idx_d    = '0;
                                tx_loaded_d = 1'b0;
                                state_d     = (txc_q == '0) ? HOLD : TX;
                            end
                        end
                    end
                end
                TX: begin
                    if (sck_fall) begin
                        if (!tx_loaded_q) begin
                            tx_buf_d    = tx_data;
                            tx_loaded_d = 1'b1;
                            dio_o_d     = cur_in[bit_pos];
                        end else begin
                            dio_o_d = cur_buf[bit_pos];
                        end
                        dio_e_d = 1'b1;
                    end
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            tx_idx_d = tx_idx_q + 1'b1;
                            if (tx_idx_q == txc_q - 1'b1) begin
                                dio_e_d = 1'b0;
                                state_d = HOLD;
                            end
                        end
                    end
                end
                HOLD: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ta_q         <= '0;
            txc_q        <= '0;
            rx_cnt_q     <= '0;
            rx_len_q     <= '0;
            tx_idx_q     <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_byte_q    <= '0;
            rx_data_q    <= '0;
            tx_buf_q     <= '0;
            tx_loaded_q  <= 1'b0;
            rx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
            partial_q    <= 1'b0;
            busy_q       <= 1'b0;
            dio_o_q      <= 1'b1;
            dio_e_q      <= 1'b0;
        end else begin
            ta_q         <= ta_d;
            txc_q        <= txc_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_len_q     <= rx_len_d;
            tx_idx_q     <= tx_idx_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_byte_q    <= rx_byte_d;
            rx_data_q    <= rx_data_d;
            tx_buf_q     <= tx_buf_d;
            tx_loaded_q  <= tx_loaded_d;
            rx_valid_q   <= rx_valid_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
            partial_q    <= partial_d;
            busy_q       <= busy_d;
            dio_o_q      <= dio_o_d;
            dio_e_q      <= dio_e_d;
        end
    end

    assign dio_o         = dio_o_q;
    assign dio_e         = dio_e_q;
    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_len        = rx_len_q;
    assign frame_done    = frame_done_q;
    assign rx_overflow   = ovf_q;
    assign rx_partial    = partial_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_spi_3wire_peripheral.sv
// Drives two peripherals (MSB-first/8-byte and LSB-first/2-byte) from one SPI
// controller model and compares their outputs with a byte-level frame model.
module tb_spi_3wire_peripheral;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sck = 1'b1;
    logic        cs_n = 1'b1;
    logic        dio_i = 1'b0;
    logic [3:0]  ta = '0;
    logic [2:0]  txc = '0;
    logic [31:0] txd = '0;

    logic        dio_o_a, dio_e_a, rxv_a, fd_a, ovf_a, part_a, busy_a;
    logic [7:0]  rx_byte_a;
    logic [63:0] rx_data_a;
    logic [3:0]  rx_len_a;
    logic        dio_o_b, dio_e_b, rxv_b, fd_b, ovf_b, part_b, busy_b;
    logic [7:0]  rx_byte_b;
    logic [15:0] rx_data_b;
    logic [1:0]  rx_len_b;

    int n_checks = 0;
    int n_err = 0;
    int nv_a = 0, nv_b = 0, nfd_a = 0, nfd_b = 0, ne_a = 0, ne_b = 0;
    logic [7:0] wq[$];

    always #5 clk = ~clk;

    spi_3wire_peripheral u_a (
        .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .dio_i(dio_i),
        .dio_o(dio_o_a), .dio_e(dio_e_a), .turnaround(ta), .tx_count(txc),
        .tx_data(txd), .rx_byte(rx_byte_a), .rx_byte_valid(rxv_a),
        .rx_data(rx_data_a), .rx_len(rx_len_a), .frame_done(fd_a),
        .rx_overflow(ovf_a), .rx_partial(part_a), .busy(busy_a));

    spi_3wire_peripheral #(.RX_BYTES(2), .LSB_FIRST(1'b1)) u_b (
        .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .dio_i(dio_i),
        .dio_o(dio_o_b), .dio_e(dio_e_b), .turnaround(ta[1:0]), .tx_count(txc),
        .tx_data(txd), .rx_byte(rx_byte_b), .rx_byte_valid(rxv_b),
        .rx_data(rx_data_b), .rx_len(rx_len_b), .frame_done(fd_b),
        .rx_overflow(ovf_b), .rx_partial(part_b), .busy(busy_b));

    always @(posedge clk) begin
        if (rxv_a)   nv_a  <= nv_a + 1;
        if (rxv_b)   nv_b  <= nv_b + 1;
        if (fd_a)    nfd_a <= nfd_a + 1;
        if (fd_b)    nfd_b <= nfd_b + 1;
        if (dio_e_a) ne_a  <= ne_a + 1;
        if (dio_e_b) ne_b  <= ne_b + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // controller changes data on SCK fall; the target samples on SCK rise
    task automatic write_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sck = 1'b0; dio_i = b[7-i]; clks(8);
            sck = 1'b1; clks(8);
        end
    endtask

    task automatic read_byte(output logic [7:0] va, output logic [7:0] vb, output int ebad);
        ebad = 0;
        for (int i = 0; i < 8; i++) begin
            sck = 1'b0; clks(8); #1;
            va[7-i] = dio_o_a;
            vb[i]   = dio_o_b;
            if (!(dio_e_a && dio_e_b)) ebad++;
            sck = 1'b1; clks(8);
        end
    endtask

    task automatic do_frame(input int ta_v, input int ntx);
        int nw, s_va, s_vb, s_fa, s_fb, s_ea, s_eb, ebad, la, lb;
        logic [7:0]  va, vb;
        logic [63:0] exp_a, mask_a;
        logic [15:0] exp_b, mask_b;
        nw = wq.size();
        ta = 4'(ta_v);
        txc = 3'(ntx);
        s_va = nv_a; s_vb = nv_b; s_fa = nfd_a; s_fb = nfd_b; s_ea = ne_a; s_eb = ne_b;
        cs_n = 1'b0; clks(10);
        check("busy_a", busy_a, 1);
        foreach (wq[i]) write_bits(wq[i], 8);
        check("e_during_write", (ne_a - s_ea) + (ne_b - s_eb), 0);
        if (ta_v > 0) begin
            if (ntx == 0) begin
                read_byte(va, vb, ebad);
                check("e_tx0", (ne_a - s_ea) + (ne_b - s_eb), 0);
            end else begin
                for (int k = 0; k < ntx; k++) begin
                    read_byte(va, vb, ebad);
                    check("read_a", va, txd[8*k +: 8]);
                    check("read_b", vb, txd[8*k +: 8]);
                    check("e_read", ebad, 0);
                end
            end
        end
        clks(8); #1;
        check("release", {dio_e_a, dio_e_b}, 0);
        cs_n = 1'b1; clks(10); #1;
        check("fd_a", nfd_a - s_fa, 1);
        check("fd_b", nfd_b - s_fb, 1);
        check("valid_a", nv_a - s_va, nw);
        check("valid_b", nv_b - s_vb, nw);
        la = (nw < 8) ? nw : 8;
        lb = (nw < 2) ? nw : 2;
        check("len_a", rx_len_a, la);
        check("len_b", rx_len_b, lb);
        check("ovf_a", ovf_a, nw > 8);
        check("ovf_b", ovf_b, nw > 2);
        exp_a = '0; mask_a = '0; exp_b = '0; mask_b = '0;
        for (int i = 0; i < la; i++) begin
            exp_a[8*i +: 8] = wq[i]; mask_a[8*i +: 8] = 8'hFF;
        end
        for (int i = 0; i < lb; i++) begin
            exp_b[8*i +: 8] = rev8(wq[i]); mask_b[8*i +: 8] = 8'hFF;
        end
        check("rxdata_a", rx_data_a & mask_a, exp_a);
        check("rxdata_b", rx_data_b & mask_b, exp_b);
        check("rxbyte_a", rx_byte_a, wq[nw-1]);
        check("rxbyte_b", rx_byte_b, rev8(wq[nw-1]));
        check("partial", {part_a, part_b}, 0);
        check("busy_end", {busy_a, busy_b}, 0);
    endtask

    initial begin
        int s_fa, s_ea, ta_v, ntx, nw;
        logic [7:0] b;

        clks(5); reset = 1'b0; clks(6); #1;
        check("rst_dio_o", {dio_o_a, dio_o_b}, 2'b11);
        check("rst_dio_e", {dio_e_a, dio_e_b}, 0);
        check("rst_busy", {busy_a, busy_b}, 0);
        check("rst_len", {rx_len_a, rx_len_b}, 0);
        check("rst_data_a", rx_data_a, 0);
        check("rst_flags", {ovf_a, part_a, ovf_b, part_b}, 0);
        check("rst_fd", nfd_a + nfd_b, 0);

        wq = '{8'h8F, 8'hA5, 8'h3C};
        do_frame(0, 0);

        wq = '{8'h42};
        txd = 32'h0000_C35A;
        do_frame(1, 2);

        wq = '{8'h11, 8'h22, 8'h33};
        do_frame(0, 0);

        // partial second byte, then a clean frame clears the flag
        ta = '0; txc = '0;
        s_fa = nfd_a;
        cs_n = 1'b0; clks(10);
        write_bits(8'h5C, 8);
        write_bits(8'hAA, 5);
        cs_n = 1'b1; clks(10); #1;
        check("part_len", {rx_len_a, 2'b00, rx_len_b}, {4'd1, 2'b00, 2'd1});
        check("part_flag", {part_a, part_b}, 2'b11);
        check("part_fd", nfd_a - s_fa, 1);
        check("part_data", rx_data_a[7:0], 8'h5C);
        wq = '{8'hFF};
        do_frame(0, 0);

        // reset in the middle of a response byte
        ta = 4'd1; txc = 3'd2; txd = $urandom;
        cs_n = 1'b0; clks(10);
        write_bits(8'h99, 8);
        for (int i = 0; i < 4; i++) begin
            sck = 1'b0; clks(8); sck = 1'b1; clks(8);
        end
        sck = 1'b0; clks(8); #1;
        check("pre_rst_e", dio_e_a, 1);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("rst_e_now", {dio_e_a, dio_e_b}, 0);
        check("rst_busy_now", {busy_a, busy_b}, 0);
        reset = 1'b0;
        s_fa = nfd_a; s_ea = ne_a;
        sck = 1'b1; clks(8);
        for (int i = 0; i < 11; i++) begin
            sck = 1'b0; clks(8); sck = 1'b1; clks(8);
        end
        check("post_rst_e", ne_a - s_ea, 0);
        check("post_rst_busy", busy_a, 0);
        cs_n = 1'b1; clks(10); #1;
        check("post_rst_fd", nfd_a - s_fa, 0);
        wq = '{8'h42};
        txd = 32'hDEAD_BE5A;
        do_frame(1, 1);

        for (int f = 0; f < 10; f++) begin
            ta_v = $urandom_range(0, 3);
            ntx  = $urandom_range(0, 4);
            nw   = (ta_v == 0) ? $urandom_range(1, 10) : ta_v;
            txd  = $urandom;
            wq.delete();
            for (int i = 0; i < nw; i++) begin
                b = 8'($urandom);
                wq.push_back(b);
            end
            do_frame(ta_v, ntx);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
